// File: rtl/strobe_rate_bridge.sv
// Strobe-rate bridge: a small circular FIFO between an input clock-enable (eni)
// and an output clock-enable (eno). A prefill stage holds off reads until enough samples are buffered.
module strobe_rate_bridge #(
  parameter int W       = 10,
  parameter int DEPTH   = 4,
  parameter int PREFILL = 2,
  parameter int CNTW    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       eni,
  input  logic                       eno,
  input  logic signed [W-1:0]        in,
  input  logic                       hold_mode,
  input  logic                       resync_en,
  input  logic                       clr_stat,
  output logic signed [W-1:0]        out,
  output logic                       out_vld,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       running,
  output logic [CNTW-1:0]            ovf_cnt,
  output logic [CNTW-1:0]            unf_cnt,
  output logic                       ovf_flag,
  output logic                       unf_flag
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] PRE_LVL  = LW'(PREFILL);

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

  state_t                r_state, w_state_nxt;
  logic [W-1:0]          r_mem [DEPTH];
  logic [AW-1:0]         r_wp, r_rp;
  logic [LW-1:0]         r_level, w_level_nxt;
  logic signed [W-1:0]   r_out;
  logic                  r_out_vld;
  logic [CNTW-1:0]       r_ovf_cnt, r_unf_cnt;
  logic                  r_ovf_flag, r_unf_flag;

  logic w_rd, w_wr, w_ovf, w_unf, w_fill;

  // A read in the same cycle frees a slot, so a full FIFO still accepts a write.
  assign w_rd   = eno && (r_state == RUN) && (r_level != '0);
  assign w_wr   = eni && ((r_level != FULL_LVL) || w_rd);
  assign w_ovf  = eni && !w_wr;
  assign w_fill = eno && !w_rd;
  assign w_unf  = eno && (r_state == RUN) && (r_level == '0);

  assign w_level_nxt = r_level + LW'(w_wr) - LW'(w_rd);

  // Saturating event counter; an event in the same cycle as a clear leaves it at 1.
  function automatic logic [CNTW-1:0] f_cnt_nxt(input logic [CNTW-1:0] cnt,
                                                input logic ev, input logic clr);
    logic [CNTW-1:0] base;
    base = clr ? '0 : cnt;
    if (ev && (base != '1)) return base + 1'b1;
    return base;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FILL:    if (w_level_nxt >= PRE_LVL) w_state_nxt = RUN;
      RUN:     if (w_unf && resync_en)     w_state_nxt = FILL;
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= FILL;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp      <= '0;
      r_rp      <= '0;
      r_level   <= '0;
      r_out     <= '0;
      r_out_vld <= 1'b0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      r_level   <= w_level_nxt;
      r_out_vld <= w_rd;
      if (w_rd)                     r_out <= r_mem[r_rp];
      else if (w_fill && !hold_mode) r_out <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf_cnt  <= '0;
      r_unf_cnt  <= '0;
      r_ovf_flag <= 1'b0;
      r_unf_flag <= 1'b0;
    end else begin
      r_ovf_cnt  <= f_cnt_nxt(r_ovf_cnt, w_ovf, clr_stat);
      r_unf_cnt  <= f_cnt_nxt(r_unf_cnt, w_unf, clr_stat);
      r_ovf_flag <= w_ovf || (r_ovf_flag && !clr_stat);
      r_unf_flag <= w_unf || (r_unf_flag && !clr_stat);
    end
  end

  assign out      = r_out;
  assign out_vld  = r_out_vld;
  assign level    = r_level;
  assign running  = (r_state == RUN);
  assign ovf_cnt  = r_ovf_cnt;
  assign unf_cnt  = r_unf_cnt;
  assign ovf_flag = r_ovf_flag;
  assign unf_flag = r_unf_flag;

endmodule

// File: doc/strobe_rate_bridge.md
Name: strobe_rate_bridge

Overview:
- Sample-rate bridge between two clock-enable strobe domains on one clk: producer writes samples on eni, consumer takes one sample per eno.
- Small circular FIFO absorbs phase/jitter between the strobes.
- Prefill FSM delays the first outputs until the FIFO holds a margin of samples.
- Underflow is filled with zero or with the last sample; overflow drops the new sample. Both events are counted for the LPDAQ status path.

Parameters:
- W, 10, sample width, two's-complement signed
- DEPTH, 4, FIFO entries; power of 2, >= 2
- PREFILL, 2, level required before leaving FILL; 1..DEPTH
- CNTW, 16, width of the saturating event counters

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: synchronous, active-low
- eni  in  1  input strobe; `in` valid this cycle
- eno  in  1  output strobe; consumer takes `out` on the cycle after eno
- in  in  W  signed input sample
- hold_mode  in  1  underflow fill: 0 = zero, 1 = repeat last out
- resync_en  in  1  1 = underflow in RUN returns FSM to FILL
- clr_stat  in  1  synchronous clear of counters and sticky flags
- out  out  W  signed output sample; registered
- out_vld  out  1  1-cycle pulse, 1 cycle after eno whose sample came from the FIFO
- level  out  $clog2(DEPTH)+1  current FIFO occupancy
- running  out  1  FSM in RUN
- ovf_cnt  out  CNTW  dropped-input count, saturating
- unf_cnt  out  CNTW  RUN-state underflow count, saturating
- ovf_flag  out  1  sticky overflow flag
- unf_flag  out  1  sticky underflow flag

Behaviour:

Reset (rst_n = 0 at a clk edge):
- out = 0, out_vld = 0, level = 0, running = 0.
- Counters and flags = 0; FSM = FILL.
- Read and write pointers = 0; FIFO contents are don't-care.
- Reset has priority over all other inputs. A reset mid-stream discards buffered samples.

FIFO:
- Write pointer wp and read pointer rp, each log2(DEPTH) bits, wrap naturally modulo DEPTH.
- level is a separate counter, range 0..DEPTH.

Write (eni = 1):
- If level < DEPTH, or a read occurs in the same cycle: store `in` at wp, increment wp.
- Otherwise drop the sample, increment ovf_cnt (saturating at 2^CNTW-1), set ovf_flag.

Read (eno = 1 and FSM = RUN and level > 0):
- out <= mem[rp], increment rp, out_vld <= 1.
- A write in the same cycle is not readable that cycle; the read sees only pre-edge contents.

Underflow fill:
- Applies when eno = 1 and (FSM = FILL, or level = 0).
- out <= (hold_mode ? out : 0), out_vld <= 0.
- In RUN with level = 0: increment unf_cnt (saturating), set unf_flag.
- FILL-state fills are not counted.

Level update:
- level_next = level + write_accepted − read_done.
- Simultaneous write and read leave level unchanged, including at full and at empty+1.

When eno = 0:
- out holds its value, out_vld = 0.

FSM:
- FILL → RUN when level_next >= PREFILL. The first read can occur on the next eno.
- RUN → FILL on a counted underflow when resync_en = 1.
- RUN stays in RUN on underflow when resync_en = 0.
- running = (state == RUN), registered.

Latency:
- In steady state an accepted sample appears on `out` on the (level-at-write + 1)-th eno after its eni.
- Minimum latency is 1 eno strobe plus 1 clk.

Status clear:
- clr_stat = 1 zeroes both counters and both flags.
- If an event occurs in the same cycle, the counter is set to 1 and the flag is set (event wins over clear).

Width and data:
- No arithmetic on data; samples pass bit-exact.
- Counter saturation: increment is blocked at the all-ones value.

Test Plan:
- Prefill: PREFILL=2; eno every 2 cycles, eni 1,2 then 3,4 at 4-cycle spacing → out = 0 with out_vld = 0 until level = 2; then out = 1, 2, 3, ... with out_vld pulses; unf_cnt = 0.
- Interp underflow: in RUN, hold_mode = 0, resync_en = 0; eno at 3× the eni rate, in = 100, −50 → out sequence 100, 0, 0, −50, 0, 0; unf_cnt increments on each zero; FSM stays in RUN.
- Hold and resync: hold_mode = 1, resync_en = 1; last out = −7, FIFO empties, eno → out stays −7, unf_cnt = 1, running drops to 0; next two eni → running returns to 1.
- Overflow: DEPTH=4, no eno, eni with in = 1..6 → level = 4, ovf_cnt = 2, ovf_flag = 1; after RUN, reads give 1, 2, 3, 4.
- Full boundary: level = 4 and eni & eno in the same cycle → write accepted, level stays 4, ovf_cnt unchanged, out = oldest sample.
- Reset and clear: rst_n low mid-stream with level = 3 → next cycle level = 0, out = 0, FILL. Separately: ovf_cnt preset to 0xFFFF, another overflow → ovf_cnt stays 0xFFFF. clr_stat together with an underflow → unf_cnt = 1.
